// File: rtl/fetch_stage.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage with its IF/ID pipeline register. Owns the PC,
// keeps exactly one instruction-memory request in flight, registers the
// returned word and presents it to decode. Honours a downstream stall and a
// branch redirect coming from the EX/branch logic.
//
// Parameters
//   PC_W      PC / address width (instruction word is always 32 bits)
//   RESET_PC  PC loaded on reset, must be word aligned
//
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   imem_req       out  request pending; imem_addr is stable while high
//   imem_addr      out  word-aligned fetch address
//   imem_valid     in   one-cycle pulse, imem_rdata holds the word for imem_addr
//   imem_rdata     in   instruction word
//   stall          in   downstream cannot accept; hold IF/ID
//   branch_taken   in   redirect request (one-cycle pulse)
//   branch_target  in   redirect address, low two bits ignored
//   if_id_valid    out  IF/ID holds a real instruction
//   if_id_instr    out  registered instruction, zero (NOP) when invalid
//   if_id_pc4      out  address of that instruction + 4
//   opcode         out  if_id_instr[31:26], straight to the control unit
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter int unsigned     PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [31:0]     imem_rdata,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic            if_id_valid,
    output logic [31:0]     if_id_instr,
    output logic [PC_W-1:0] if_id_pc4,
    output logic [5:0]      opcode
);

    localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } state_t;

    state_t          state, state_n;
    logic            req_en;
    logic            drop, drop_n;
    logic [PC_W-1:0] pc, pc_n;
    logic [PC_W-1:0] pc_plus4;
    logic [PC_W-1:0] branch_pc;
    logic [PC_W-1:0] drop_addr, drop_addr_n;
    logic [31:0]     hold_word;
    logic            hold_load;
    logic            fire;
    logic            if_valid_n;
    logic [31:0]     if_instr_n;
    logic [PC_W-1:0] if_pc4_n;
    logic [1:0]      unused_target_lsbs;

    assign unused_target_lsbs = branch_target[1:0];

    // Request side: a request is outstanding whenever we are fetching and
    // the first post-reset cycle has passed. While a response is being
    // dropped the old address must stay on the bus until it returns.
    assign imem_req  = req_en && (state == S_FETCH);
    assign imem_addr = drop ? drop_addr : pc;
    assign fire      = imem_req && imem_valid;
    assign pc_plus4  = pc + PC_STEP;
    assign branch_pc = {branch_target[PC_W-1:2], 2'b00};
    assign opcode    = if_id_instr[31:26];

    // Next-state logic. When downstream is not stalled it consumes IF/ID
    // every cycle, so a cycle without a new word leaves a bubble behind;
    // if_id_pc4 is left alone in a bubble since it is meaningless then.
    always_comb begin
        state_n     = state;
        pc_n        = pc;
        drop_n      = drop;
        drop_addr_n = drop_addr;
        if_valid_n  = if_id_valid;
        if_instr_n  = if_id_instr;
        if_pc4_n    = if_id_pc4;
        hold_load   = 1'b0;

        if (branch_taken) begin
            // Redirect wins over stall and any response in this cycle.
            pc_n       = branch_pc;
            if_valid_n = 1'b0;
            if_instr_n = 32'h0;
            state_n    = S_FETCH;
            if (drop) begin
                // Already discarding; only the arriving response clears it.
                drop_n = !fire;
            end else if (imem_req && !imem_valid) begin
                drop_n      = 1'b1;
                drop_addr_n = pc;
            end
        end else if (drop) begin
            if (fire) begin
                drop_n = 1'b0;
            end
            if (!stall) begin
                if_valid_n = 1'b0;
                if_instr_n = 32'h0;
            end
        end else if (state == S_HOLD) begin
            if (!stall) begin
                if_valid_n = 1'b1;
                if_instr_n = hold_word;
                if_pc4_n   = pc_plus4;
                pc_n       = pc_plus4;
                state_n    = S_FETCH;
            end
        end else if (fire) begin
            if (stall) begin
                hold_load = 1'b1;
                state_n   = S_HOLD;
            end else begin
                if_valid_n = 1'b1;
                if_instr_n = imem_rdata;
                if_pc4_n   = pc_plus4;
                pc_n       = pc_plus4;
            end
        end else if (!stall) begin
            if_valid_n = 1'b0;
            if_instr_n = 32'h0;
        end
    end

    // IF/ID boundary and fetch control state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_FETCH;
            req_en      <= 1'b0;
            drop        <= 1'b0;
            pc          <= RESET_PC;
            if_id_valid <= 1'b0;
            if_id_instr <= 32'h0;
            if_id_pc4   <= '0;
        end else begin
            state       <= state_n;
            req_en      <= 1'b1;
            drop        <= drop_n;
            pc          <= pc_n;
            if_id_valid <= if_valid_n;
            if_id_instr <= if_instr_n;
            if_id_pc4   <= if_pc4_n;
        end
    end

    // Data-only registers: their contents matter only while drop is set or
    // the FSM is in HOLD, both of which are cleared by reset.
    always_ff @(posedge clk) begin
        drop_addr <= drop_addr_n;
        if (hold_load) begin
            hold_word <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic [5:0]  opcode;

    // Second instance for the PC wrap case: memory answers immediately.
    logic        w_rst_n = 1'b0;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_valid;
    logic [31:0] w_rdata = 32'h1234_5678;
    logic        w_stall = 1'b0;
    logic        w_br = 1'b0;
    logic [31:0] w_tgt = 32'h0;
    logic        w_ifv;
    logic [31:0] w_instr;
    logic [31:0] w_pc4;
    logic [5:0]  w_op;

    assign w_valid = w_req;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fetch_stage #(.PC_W(32), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
        .if_id_pc4(if_id_pc4), .opcode(opcode)
    );

    fetch_stage #(.PC_W(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .rst_n(w_rst_n),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_valid(w_valid), .imem_rdata(w_rdata),
        .stall(w_stall), .branch_taken(w_br), .branch_target(w_tgt),
        .if_id_valid(w_ifv), .if_id_instr(w_instr),
        .if_id_pc4(w_pc4), .opcode(w_op)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic e_req, input logic [31:0] e_addr,
                             input logic e_v, input logic [31:0] e_i, input logic [31:0] e_p);
        check({tag, ".imem_req"}, 32'(imem_req), 32'(e_req));
        check({tag, ".imem_addr"}, imem_addr, e_addr);
        check({tag, ".if_id_valid"}, 32'(if_id_valid), 32'(e_v));
        check({tag, ".if_id_instr"}, if_id_instr, e_i);
        check({tag, ".if_id_pc4"}, if_id_pc4, e_p);
        check({tag, ".opcode"}, 32'(opcode), 32'(e_i[31:26]));
    endtask

    typedef struct {
        logic        v;
        logic [31:0] d;
        logic        s;
        logic        b;
        logic [31:0] t;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_v;
        logic [31:0] e_i;
        logic [31:0] e_p;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [31:0] d, input logic s,
                                input logic b, input logic [31:0] t, input logic e_req,
                                input logic [31:0] e_addr, input logic e_v,
                                input logic [31:0] e_i, input logic [31:0] e_p);
        vec_t r;
        r.v = v; r.d = d; r.s = s; r.b = b; r.t = t;
        r.e_req = e_req; r.e_addr = e_addr; r.e_v = e_v; r.e_i = e_i; r.e_p = e_p;
        return r;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    localparam logic [31:0] W0   = 32'h8C01_0004;
    localparam logic [31:0] W4   = 32'h0022_1820;
    localparam logic [31:0] W8   = 32'h2002_000A;
    localparam logic [31:0] W12  = 32'hAC03_0008;
    localparam logic [31:0] W16  = 32'h1234_5678;
    localparam logic [31:0] W40  = 32'h0800_0010;
    localparam logic [31:0] W44  = 32'hFFFF_FFFF;
    localparam logic [31:0] W80  = 32'h3C01_ABCD;
    localparam logic [31:0] W84  = 32'h1000_0000;
    localparam logic [31:0] W200 = 32'h2442_0001;
    localparam logic [31:0] JUNK = 32'hDEAD_BEEF;

    // Reference model state for the random phase.
    logic [31:0] m_pc, m_drop_addr, m_ifi, m_ifp;
    logic        m_started, m_drop, m_ifv;
    logic [31:0] hq[$];

    initial begin
        vec_t tbl[19];
        // Each row: inputs applied this cycle, outputs expected before the edge.
        tbl[0]  = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0, 32'h0);
        tbl[1]  = mk(1'b1, W0,    1'b0, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0, 32'h0);
        tbl[2]  = mk(1'b1, W4,    1'b0, 1'b0, 32'h0,   1'b1, 32'h4,   1'b1, W0,    32'h4);
        tbl[3]  = mk(1'b1, W8,    1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, W4,    32'h8);
        tbl[4]  = mk(1'b0, 32'h0, 1'b1, 1'b0, 32'h0,   1'b0, 32'h8,   1'b1, W4,    32'h8);
        tbl[5]  = mk(1'b1, JUNK,  1'b1, 1'b0, 32'h0,   1'b0, 32'h8,   1'b1, W4,    32'h8);
        tbl[6]  = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h8,   1'b1, W4,    32'h8);
        tbl[7]  = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, W8,    32'hC);
        tbl[8]  = mk(1'b1, W12,   1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   1'b0, 32'h0, 32'hC);
        tbl[9]  = mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h43,  1'b1, 32'h10,  1'b1, W12,   32'h10);
        tbl[10] = mk(1'b0, 32'h0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b0, 32'h0, 32'h10);
        tbl[11] = mk(1'b1, W16,   1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b0, 32'h0, 32'h10);
        tbl[12] = mk(1'b1, W40,   1'b0, 1'b0, 32'h0,   1'b1, 32'h40,  1'b0, 32'h0, 32'h10);
        tbl[13] = mk(1'b1, W44,   1'b1, 1'b1, 32'h80,  1'b1, 32'h44,  1'b1, W40,   32'h44);
        tbl[14] = mk(1'b1, W80,   1'b0, 1'b0, 32'h0,   1'b1, 32'h80,  1'b0, 32'h0, 32'h44);
        tbl[15] = mk(1'b0, 32'h0, 1'b0, 1'b1, 32'h100, 1'b1, 32'h84,  1'b1, W80,   32'h84);
        tbl[16] = mk(1'b0, 32'h0, 1'b1, 1'b1, 32'h202, 1'b1, 32'h84,  1'b0, 32'h0, 32'h84);
        tbl[17] = mk(1'b1, W84,   1'b0, 1'b0, 32'h0,   1'b1, 32'h84,  1'b0, 32'h0, 32'h84);
        tbl[18] = mk(1'b1, W200,  1'b0, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0, 32'h84);

        // Reset values while held in reset.
        repeat (3) @(negedge clk);
        check_all("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        rst_n = 1'b1;

        // Directed table: fetch sequence, stall/HOLD, branch drop, branch+stall+valid.
        for (int i = 0; i < 19; i++) begin
            check_all($sformatf("vec%0d", i), tbl[i].e_req, tbl[i].e_addr,
                      tbl[i].e_v, tbl[i].e_i, tbl[i].e_p);
            imem_valid    = tbl[i].v;
            imem_rdata    = tbl[i].d;
            stall         = tbl[i].s;
            branch_taken  = tbl[i].b;
            branch_target = tbl[i].t;
            @(negedge clk);
        end
        imem_valid = 1'b0; stall = 1'b0; branch_taken = 1'b0;
        check_all("after_tbl", 1'b1, 32'h204, 1'b1, W200, 32'h204);

        // Asynchronous reset mid-request, then a stray response after release.
        #2 rst_n = 1'b0;
        #1 check_all("async_rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        imem_valid = 1'b1;
        imem_rdata = JUNK;
        check_all("rel0", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check_all("rel1", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
        imem_rdata = W0;
        @(negedge clk);
        imem_valid = 1'b0;
        check_all("rel2", 1'b1, 32'h4, 1'b1, W0, 32'h4);

        // PC wrap with RESET_PC = 0xFFFFFFFC.
        w_rst_n = 1'b1;
        check("wrap.req0", 32'(w_req), 32'(1'b0));
        check("wrap.addr0", w_addr, 32'hFFFF_FFFC);
        @(negedge clk);
        check("wrap.req1", 32'(w_req), 32'(1'b1));
        check("wrap.addr1", w_addr, 32'hFFFF_FFFC);
        check("wrap.ifv1", 32'(w_ifv), 32'(1'b0));
        @(negedge clk);
        check("wrap.ifv2", 32'(w_ifv), 32'(1'b1));
        check("wrap.instr2", w_instr, 32'h1234_5678);
        check("wrap.pc4", w_pc4, 32'h0);
        check("wrap.addr2", w_addr, 32'h0);
        check("wrap.opcode", 32'(w_op), 32'(6'b000100));

        // Randomized run against the reference model.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        m_pc = 32'h0; m_started = 1'b0; m_drop = 1'b0; m_drop_addr = 32'h0;
        m_ifv = 1'b0; m_ifi = 32'h0; m_ifp = 32'h0;
        hq.delete();
        begin
            int age;
            int lat;
            age = 0;
            lat = 1;
            for (int cyc = 0; cyc < 3000; cyc++) begin
                logic        e_req, v, s, b, fire;
                logic [31:0] e_addr, d, t, old_pc;
                e_req  = m_started && (hq.size() == 0);
                e_addr = m_drop ? m_drop_addr : m_pc;
                check_all("rand", e_req, e_addr, m_ifv, m_ifi, m_ifp);

                // Memory: answers lat cycles into each request, occasional strays.
                v = 1'b0;
                d = $urandom;
                if (e_req) begin
                    age++;
                    if (age >= lat) begin
                        v   = 1'b1;
                        d   = mem_word(e_addr);
                        age = 0;
                        lat = int'($urandom_range(1, 3));
                    end
                end else begin
                    age = 0;
                    v   = ($urandom % 8) == 0;
                end
                s = ($urandom % 4) == 0;
                b = ($urandom % 16) == 0;
                t = $urandom;

                imem_valid = v; imem_rdata = d; stall = s;
                branch_taken = b; branch_target = t;

                fire = e_req && v;
                if (b) begin
                    old_pc = m_pc;
                    m_pc   = t & ~32'h3;
                    m_ifv  = 1'b0;
                    m_ifi  = 32'h0;
                    hq.delete();
                    if (m_drop) begin
                        if (fire) m_drop = 1'b0;
                    end else if (e_req && !v) begin
                        m_drop      = 1'b1;
                        m_drop_addr = old_pc;
                    end
                end else if (m_drop) begin
                    if (fire) m_drop = 1'b0;
                    if (!s) begin m_ifv = 1'b0; m_ifi = 32'h0; end
                end else if (hq.size() != 0) begin
                    if (!s) begin
                        m_ifv = 1'b1;
                        m_ifi = hq.pop_front();
                        m_ifp = m_pc + 32'd4;
                        m_pc  = m_pc + 32'd4;
                    end
                end else if (fire) begin
                    if (s) begin
                        hq.push_back(d);
                    end else begin
                        m_ifv = 1'b1;
                        m_ifi = d;
                        m_ifp = m_pc + 32'd4;
                        m_pc  = m_pc + 32'd4;
                    end
                end else if (!s) begin
                    m_ifv = 1'b0;
                    m_ifi = 32'h0;
                end
                m_started = 1'b1;
                @(negedge clk);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
